// File: rtl/fmul_s1_vec.sv
// Vector FP multiplier stage 1: decode, special-case classification and exponent/shift prep, one register stage.
// Optional sticky invalid/overflow accumulators are built when FMUL_S1_VEC_STICKY_FLAGS_EN is defined.
`ifndef TC_EXPWIDTH
`define TC_EXPWIDTH 5
`endif
`ifndef TC_PRECISION
`define TC_PRECISION 3
`endif

module fmul_s1_vec #(
  parameter int EXPWIDTH  = `TC_EXPWIDTH,
  parameter int PRECISION = `TC_PRECISION,
  parameter int LANES     = 4,
  parameter int USERW     = 8,
  localparam int W        = 1 + EXPWIDTH + PRECISION,
  localparam int EW2      = EXPWIDTH + 2,
  localparam int SW       = EXPWIDTH + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [LANES*W-1:0]     s_axis_tdata_a,
  input  logic [LANES*W-1:0]     s_axis_tdata_b,
  input  logic [USERW-1:0]       s_axis_tuser,
  input  logic [2:0]             rm_i,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [USERW-1:0]       m_axis_tuser,
  output logic [2:0]             out_rm_o,
  output logic [LANES*7-1:0]     out_lane_flags_o,
  output logic [LANES-1:0]       out_prod_sign_o,
  output logic [LANES*EW2-1:0]   out_exp_shifted_o,
  output logic [LANES*SW-1:0]    out_shift_amt_o,
  input  logic                   flags_clr_i,
  output logic                   sticky_nv_o,
  output logic                   sticky_of_o
);

  localparam int BIAS = (1 << (EXPWIDTH - 1)) - 1;
  localparam logic signed [EW2-1:0] BIAS_S  = EW2'(BIAS);
  localparam logic signed [EW2-1:0] ONE_S   = EW2'(1);
  localparam logic signed [EW2-1:0] OVF_S   = EW2'((1 << EXPWIDTH) - 1);
  localparam logic signed [EW2-1:0] MAXSH_S = EW2'(2 * PRECISION + 3);

  logic                 mValid_q;
  logic [USERW-1:0]     user_q;
  logic [2:0]           rm_q;
  logic [LANES*7-1:0]   laneFlags_q, laneFlags_d;
  logic [LANES-1:0]     sign_q, sign_d;
  logic [LANES*EW2-1:0] expSh_q, expSh_d;
  logic [LANES*SW-1:0]  shift_q, shift_d;
  logic                 accept;

  assign s_axis_tready = ~mValid_q | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;

  for (genvar k = 0; k < LANES; k++) begin : gLane
    logic [W-1:0]            aOp, bOp;
    logic [EXPWIDTH-1:0]     aExp, bExp;
    logic                    aExpZero, bExpZero, aExpOnes, bExpOnes, aFracNz, bFracNz;
    logic                    aZero, bZero, aSub, bSub, aInf, bInf, aNan, bNan;
    logic                    validSc, isNan, isInf, isInv, hasZero, earlyOvf, maySub, under;
    logic signed [EW2-1:0]   aEff, bEff, expSh, shDiff;
    logic [SW-1:0]           shClamp;

    assign aOp      = s_axis_tdata_a[k*W +: W];
    assign bOp      = s_axis_tdata_b[k*W +: W];
    assign aExp     = aOp[W-2 -: EXPWIDTH];
    assign bExp     = bOp[W-2 -: EXPWIDTH];
    assign aFracNz  = |aOp[PRECISION-1:0];
    assign bFracNz  = |bOp[PRECISION-1:0];
    assign aExpZero = (aExp == '0);
    assign bExpZero = (bExp == '0);
    assign aExpOnes = &aExp;
    assign bExpOnes = &bExp;

    assign aZero = aExpZero & ~aFracNz;
    assign bZero = bExpZero & ~bFracNz;
    assign aSub  = aExpZero & aFracNz;
    assign bSub  = bExpZero & bFracNz;
    assign aInf  = aExpOnes & ~aFracNz;
    assign bInf  = bExpOnes & ~bFracNz;
    assign aNan  = aExpOnes & aFracNz;
    assign bNan  = bExpOnes & bFracNz;

    assign isInv   = (aInf & bZero) | (bInf & aZero);
    assign isNan   = aNan | bNan | isInv;
    assign isInf   = (aInf & ~bZero & ~bNan) | (bInf & ~aZero & ~aNan);
    assign hasZero = aZero | bZero;
    assign validSc = aZero | bZero | aInf | bInf | aNan | bNan;

    // Subnormal operands take an effective exponent of 1
    assign aEff  = aExpZero ? ONE_S : $signed({2'b00, aExp});
    assign bEff  = bExpZero ? ONE_S : $signed({2'b00, bExp});
    assign expSh = aEff + bEff - BIAS_S;

    assign under    = (expSh < ONE_S);
    assign earlyOvf = ~validSc & (expSh >= OVF_S);
    assign maySub   = ~validSc & (aSub | bSub | under);
    assign shDiff   = ONE_S - expSh;
    assign shClamp  = (shDiff > MAXSH_S) ? MAXSH_S[SW-1:0] : shDiff[SW-1:0];

    assign laneFlags_d[k*7 +: 7] = {validSc, isNan, isInf, isInv, hasZero, earlyOvf, maySub};
    assign sign_d[k]             = aOp[W-1] ^ bOp[W-1];
    assign expSh_d[k*EW2 +: EW2] = expSh;
    assign shift_d[k*SW +: SW]   = (under & ~validSc) ? shClamp : '0;
  end

  // Output register: loads on accept, holds while downstream stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mValid_q    <= 1'b0;
      user_q      <= '0;
      rm_q        <= '0;
      laneFlags_q <= '0;
      sign_q      <= '0;
      expSh_q     <= '0;
      shift_q     <= '0;
    end else begin
      if (s_axis_tready) mValid_q <= s_axis_tvalid;
      if (accept) begin
        user_q      <= s_axis_tuser;
        rm_q        <= rm_i;
        laneFlags_q <= laneFlags_d;
        sign_q      <= sign_d;
        expSh_q     <= expSh_d;
        shift_q     <= shift_d;
      end
    end
  end

  assign m_axis_tvalid     = mValid_q;
  assign m_axis_tuser      = user_q;
  assign out_rm_o          = rm_q;
  assign out_lane_flags_o  = laneFlags_q;
  assign out_prod_sign_o   = sign_q;
  assign out_exp_shifted_o = expSh_q;
  assign out_shift_amt_o   = shift_q;

`ifdef FMUL_S1_VEC_STICKY_FLAGS_EN
  logic stickyNv_q, stickyNv_d, stickyOf_q, stickyOf_d;
  logic anyInv, anyOvf;

  // A set in the same cycle as a clear wins
  always_comb begin
    anyInv = 1'b0;
    anyOvf = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      anyInv = anyInv | laneFlags_d[k*7 + 3];
      anyOvf = anyOvf | laneFlags_d[k*7 + 1];
    end
    stickyNv_d = (flags_clr_i ? 1'b0 : stickyNv_q) | (accept & anyInv);
    stickyOf_d = (flags_clr_i ? 1'b0 : stickyOf_q) | (accept & anyOvf);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stickyNv_q <= 1'b0;
      stickyOf_q <= 1'b0;
    end else begin
      stickyNv_q <= stickyNv_d;
      stickyOf_q <= stickyOf_d;
    end
  end

  assign sticky_nv_o = stickyNv_q;
  assign sticky_of_o = stickyOf_q;
`else
  logic unusedClr;
  assign unusedClr   = flags_clr_i;
  assign sticky_nv_o = 1'b0;
  assign sticky_of_o = 1'b0;
`endif

endmodule

// File: tb/tb_fmul_s1_vec.sv
// Scoreboard bench for fmul_s1_vec: random and directed beats checked against a plain-arithmetic lane model.
// Sticky flag expectations follow FMUL_S1_VEC_STICKY_FLAGS_EN when it is defined for the build.
module tb_fmul_s1_vec;
  localparam int EW = 5;
  localparam int P  = 3;
  localparam int L  = 4;
  localparam int UW = 8;
  localparam int W  = 1 + EW + P;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tready;
  logic [L*W-1:0]     s_axis_tdata_a = '0;
  logic [L*W-1:0]     s_axis_tdata_b = '0;
  logic [UW-1:0]      s_axis_tuser = '0;
  logic [2:0]         rm_i = '0;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b0;
  logic [UW-1:0]      m_axis_tuser;
  logic [2:0]         out_rm_o;
  logic [L*7-1:0]     out_lane_flags_o;
  logic [L-1:0]       out_prod_sign_o;
  logic [L*(EW+2)-1:0] out_exp_shifted_o;
  logic [L*(EW+1)-1:0] out_shift_amt_o;
  logic               flags_clr_i = 1'b0;
  logic               sticky_nv_o;
  logic               sticky_of_o;

  fmul_s1_vec dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata_a(s_axis_tdata_a), .s_axis_tdata_b(s_axis_tdata_b),
    .s_axis_tuser(s_axis_tuser), .rm_i(rm_i),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .out_rm_o(out_rm_o),
    .out_lane_flags_o(out_lane_flags_o), .out_prod_sign_o(out_prod_sign_o),
    .out_exp_shifted_o(out_exp_shifted_o), .out_shift_amt_o(out_shift_amt_o),
    .flags_clr_i(flags_clr_i), .sticky_nv_o(sticky_nv_o), .sticky_of_o(sticky_of_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [UW-1:0]       user;
    logic [2:0]          rm;
    logic [L*7-1:0]      flags;
    logic [L-1:0]        sign;
    logic [L*(EW+2)-1:0] exps;
    logic [L*(EW+1)-1:0] shift;
  } beat_t;

  beat_t expQ[$];
  int    compares = 0;
  int    fails    = 0;
  int    cyc      = 0;
  logic  modelNv  = 1'b0;
  logic  modelOf  = 1'b0;

  // Lane behaviour computed straight from the IEEE-style classification rules
  function automatic beat_t refModel(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                     input logic [UW-1:0] u, input logic [2:0] rm);
    beat_t r;
    logic [W-1:0] x, y;
    int  ea, eb, fa, fb, e, sh, maxExp;
    bit  za, zb, suba, subb, ia, ib, na, nb, vsc, nan, inf, inv, hz, ovf, ms;
    r = '0;
    r.user = u;
    r.rm   = rm;
    maxExp = (1 << EW) - 1;
    for (int k = 0; k < L; k++) begin
      x  = a[k*W +: W];
      y  = b[k*W +: W];
      ea = int'(x[W-2 -: EW]);
      eb = int'(y[W-2 -: EW]);
      fa = int'(x[P-1:0]);
      fb = int'(y[P-1:0]);
      za = (ea == 0) && (fa == 0);
      zb = (eb == 0) && (fb == 0);
      suba = (ea == 0) && (fa != 0);
      subb = (eb == 0) && (fb != 0);
      ia = (ea == maxExp) && (fa == 0);
      ib = (eb == maxExp) && (fb == 0);
      na = (ea == maxExp) && (fa != 0);
      nb = (eb == maxExp) && (fb != 0);
      e  = (ea == 0 ? 1 : ea) + (eb == 0 ? 1 : eb) - ((1 << (EW - 1)) - 1);
      vsc = za || zb || ia || ib || na || nb;
      inv = (ia && zb) || (ib && za);
      nan = na || nb || inv;
      inf = (ia && !zb && !nb) || (ib && !za && !na);
      hz  = za || zb;
      ovf = !vsc && (e >= maxExp);
      ms  = !vsc && (suba || subb || e < 1);
      sh  = (!vsc && e < 1) ? (((1 - e) > 2*P + 3) ? 2*P + 3 : (1 - e)) : 0;
      r.flags[k*7 +: 7]          = {vsc, nan, inf, inv, hz, ovf, ms};
      r.sign[k]                  = x[W-1] ^ y[W-1];
      r.exps[k*(EW+2) +: (EW+2)] = (EW+2)'(e);
      r.shift[k*(EW+1) +: (EW+1)] = (EW+1)'(sh);
    end
    return r;
  endfunction

  function automatic logic [L*W-1:0] randOps();
    logic [L*W-1:0] v;
    logic [EW-1:0]  ex;
    for (int k = 0; k < L; k++) begin
      case ($urandom_range(0, 7))
        0:       ex = '0;
        1:       ex = '1;
        2:       ex = EW'((1 << EW) - 2);
        default: ex = EW'($urandom_range(1, (1 << EW) - 3));
      endcase
      v[k*W +: W] = {1'($urandom_range(0, 1)), ex, P'($urandom_range(0, (1 << P) - 1))};
    end
    return v;
  endfunction

  function automatic logic pickReady(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       return $urandom_range(0, 3) != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    compares++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: every presented output must match the scoreboard head; pop on transfer
  always @(negedge clk_i) begin
    if (!rst_i && m_axis_tvalid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat", {m_axis_tuser}, 128'hDEAD);
      end else begin
        checkOutput("beat", {m_axis_tuser, out_rm_o, out_lane_flags_o, out_prod_sign_o,
                             out_exp_shifted_o, out_shift_amt_o}, expQ[0]);
        if (m_axis_tready) void'(expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                               input logic [UW-1:0] u, input logic [2:0] rm, input logic clr,
                               input logic mr, output logic acc);
    beat_t e;
    logic  setNv, setOf;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    s_axis_tvalid = v;
    s_axis_tdata_a = a;
    s_axis_tdata_b = b;
    s_axis_tuser = u;
    rm_i = rm;
    flags_clr_i = clr;
    m_axis_tready = mr;
    cyc++;
    @(negedge clk_i);
    checkOutput("sticky_nv", sticky_nv_o, modelNv);
    checkOutput("sticky_of", sticky_of_o, modelOf);
    acc = v & s_axis_tready;
    e = refModel(a, b, u, rm);
    if (acc) expQ.push_back(e);
    setNv = 1'b0;
    setOf = 1'b0;
    for (int k = 0; k < L; k++) begin
      setNv = setNv | (acc & e.flags[k*7 + 3]);
      setOf = setOf | (acc & e.flags[k*7 + 1]);
    end
`ifdef FMUL_S1_VEC_STICKY_FLAGS_EN
    modelNv = (clr ? 1'b0 : modelNv) | setNv;
    modelOf = (clr ? 1'b0 : modelOf) | setOf;
`endif
  endtask

  task automatic sendBeat(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic [UW-1:0] u,
                          input logic [2:0] rm, input logic clr, input int mode);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      applyStimulus(1'b1, a, b, u, rm, clr, pickReady(mode), acc);
      tries++;
    end
    checkOutput("accept_within_bound", acc, 1'b1);
  endtask

  task automatic idle(input int n, input logic clr, input int mode);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0, clr, pickReady(mode), acc);
  endtask

  task automatic doReset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    s_axis_tvalid = 1'b0;
    flags_clr_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("reset_tready", s_axis_tready, 1'b1);
    checkOutput("reset_sticky", {sticky_nv_o, sticky_of_o}, 2'b00);
    checkOutput("reset_data", {m_axis_tuser, out_rm_o, out_lane_flags_o, out_prod_sign_o,
                               out_exp_shifted_o, out_shift_amt_o}, '0);
    expQ.delete();
    modelNv = 1'b0;
    modelOf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  logic [L*W-1:0] dirA, dirB;

  initial begin
    doReset();

    // Lanes 3..0: min subnormal, max normal, Inf x 0, 1.0 x 1.0
    dirA = {9'h001, 9'h0F7, 9'h0F8, 9'h078};
    dirB = {9'h001, 9'h0F7, 9'h000, 9'h078};
    sendBeat(dirA, dirB, 8'hA5, 3'd2, 1'b0, 0);
    idle(3, 1'b0, 0);
    idle(1, 1'b1, 0);
    idle(2, 1'b0, 0);
    sendBeat(dirA, dirB, 8'h5A, 3'd4, 1'b1, 0);
    idle(2, 1'b0, 0);
    idle(1, 1'b1, 0);

    for (int i = 0; i < 8; i++) sendBeat(randOps(), randOps(), 8'(i), 3'($urandom_range(0, 7)), 1'b0, 1);
    idle(6, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      logic acc;
      applyStimulus($urandom_range(0, 3) != 0, randOps(), randOps(), 8'($urandom),
                    3'($urandom_range(0, 7)), $urandom_range(0, 15) == 0, pickReady(2), acc);
    end
    idle(4, 1'b0, 0);

    sendBeat(dirA, dirB, 8'h33, 3'd1, 1'b0, 3);
    idle(2, 1'b0, 3);
    doReset();
    idle(4, 1'b0, 0);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", compares, fails);
    $finish;
  end
endmodule

// File: doc/fmul_s1_vec.md
FMUL_S1_VEC -- requirements
Module: fmul_s1_vec

Interface
REQ-001 SHALL have parameter EXPWIDTH, default `TC_EXPWIDTH (5): per-operand exponent width.
REQ-002 SHALL have parameter PRECISION, default `TC_PRECISION (3): stored fraction width; operand width W = 1+EXPWIDTH+PRECISION (FP9).
REQ-003 SHALL have parameter LANES, default 4: independent multiplier lanes per beat.
REQ-004 SHALL have parameter USERW, default 8: sideband tag width.
REQ-005 SHALL have these ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted.
- s_axis_tdata_a  in  LANES*W  operand A, lane k at bits [k*W +: W].
- s_axis_tdata_b  in  LANES*W  operand B, same packing.
- s_axis_tuser  in  USERW  tag.
- rm_i  in  3  rounding mode, sampled with the beat.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  USERW  tag passthrough.
- out_rm_o  out  3  rounding mode passthrough.
- out_lane_flags_o  out  LANES*7  per lane {valid_sc, nan, inf, inv, haszero, early_ovf, may_sub}.
- out_prod_sign_o  out  LANES  per-lane product sign.
- out_exp_shifted_o  out  LANES*(EXPWIDTH+2)  per-lane signed exponent, two's complement.
- out_shift_amt_o  out  LANES*(EXPWIDTH+1)  per-lane right-shift for subnormal results.
- flags_clr_i  in  1  clear sticky flags.
- sticky_nv_o  out  1  sticky invalid.
- sticky_of_o  out  1  sticky early overflow.

Function
REQ-006 Per-lane decode SHALL classify zero, subnormal, Inf (exp all-ones, frac 0) and NaN (exp all-ones, frac≠0); BIAS = 2^(EXPWIDTH-1)-1.
REQ-007 nan = either NaN | Inf×0; inf = Inf×(non-zero, non-NaN); inv = Inf×0; haszero = either zero; valid_sc = any NaN/Inf/zero operand.
REQ-008 exp_shifted SHALL equal ea'+eb'-BIAS, computed signed in EXPWIDTH+2 bits; e' = 1 for an exponent field of 0, otherwise the field.
REQ-009 early_ovf SHALL be 1 when valid_sc=0 and exp_shifted ≥ 2^EXPWIDTH-1; otherwise 0.
REQ-010 may_sub SHALL be 1 when valid_sc=0 and (either operand is subnormal or exp_shifted < 1).
REQ-011 shift_amt SHALL be min(1-exp_shifted, 2*PRECISION+3) when exp_shifted < 1 and valid_sc=0; otherwise 0.
REQ-012 All m_axis outputs SHALL be registered; latency is 1 cycle from the input handshake (s_axis_tvalid & s_axis_tready) to m_axis_tvalid.
REQ-013 s_axis_tready SHALL be ~m_axis_tvalid | m_axis_tready; simultaneous accept and drain SHALL sustain 1 beat per cycle.
REQ-014 While m_axis_tvalid=1 and m_axis_tready=0, every m_axis-side output SHALL hold stable.
REQ-015 Lanes SHALL be independent; a special case in one lane SHALL NOT affect any other lane.

Reset
REQ-016 When rst_i=1 at a clk_i edge: m_axis_tvalid=0, and all data/flag outputs, sticky_nv_o and sticky_of_o SHALL be 0.
REQ-017 s_axis_tready SHALL be 1 in the cycle after reset.
REQ-018 A beat held in the output register when reset asserts SHALL be discarded.

Configuration
REQ-019 Macro FMUL_S1_VEC_STICKY_FLAGS_EN, when defined, SHALL build the sticky accumulators:
- sticky_nv_o |= OR of the inv bits of every accepted beat.
- sticky_of_o |= OR of the early_ovf bits of every accepted beat.
- flags_clr_i clears both on the next edge.
- If a set and flags_clr_i occur in the same cycle, the set SHALL win.
REQ-020 Without the macro, sticky_nv_o and sticky_of_o SHALL be constant 0 and flags_clr_i SHALL be ignored.

Verification
REQ-021 Lane0 A=0x078 (1.0), B=0x078 -> one cycle later exp_shifted=15, all lane flags 0, sign 0.
REQ-022 Lane1 A=0x0F8 (+Inf), B=0x000 -> nan=inv=haszero=valid_sc=1; with the macro defined, sticky_nv_o=1 until flags_clr_i is pulsed.
REQ-023 Lane2 A=B=0x0F7 (max normal) -> exp_shifted=45, early_ovf=1, sticky_of_o=1 (macro defined).
REQ-024 Lane3 A=B=0x001 (min subnormal) -> exp_shifted=-13, may_sub=1, shift_amt=9 (clamped).
REQ-025 Stream 8 beats with tuser 0..7 and m_axis_tready toggling 1,0,0,1 -> all 8 beats delivered in order, no loss or duplication, outputs stable while stalled.
REQ-026 Assert rst_i while m_axis_tvalid=1 and stalled -> next cycle m_axis_tvalid=0, sticky flags 0, s_axis_tready=1.
